dmem_arbiter: RTL and testbench

- Shares the single-port data memory (11-bit word address, combinational read, write strobe sampled on the falling clock edge) between the pipelined CPU and one burst DMA requester, such as an Ethernet receive buffer or a VGA fetch engine.
- The CPU has fixed priority. The DMA gets every free cycle once its burst is accepted.
- Sits between the CPU/write-select decode and the dmem instance in the top level.

---
 rtl/dmem_arbiter_if.sv | 48 ++++
 rtl/dmem_arbiter.sv | 154 +++++++++++++++
 tb/tb_dmem_arbiter.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the CPU, the burst DMA requester, the data memory and
// dmem_arbiter. The arbiter connects through the slave modport. The
// requester/memory side connects through the master modport.
interface dmem_arbiter_if #(
    parameter int AW = 11
);
    // CPU side
    logic          cpu_re;
    logic          cpu_we;
    logic [31:0]   cpu_addr;
    logic [31:0]   cpu_wdata;
    logic [31:0]   cpu_rdata;
    logic          cpu_stall;
    // DMA side
    logic          dma_req;
    logic          dma_we;
    logic [31:0]   dma_addr;
    logic [7:0]    dma_len;
    logic [31:0]   dma_wdata;
    logic          dma_gnt;
    logic          dma_wready;
    logic          dma_rvalid;
    logic [31:0]   dma_rdata;
    logic          dma_done;
    // Memory side
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic          mem_we;
    logic [31:0]   mem_rdata;

    modport slave (
        input  cpu_re, cpu_we, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_stall,
        input  dma_req, dma_we, dma_addr, dma_len, dma_wdata,
        output dma_gnt, dma_wready, dma_rvalid, dma_rdata, dma_done,
        output mem_addr, mem_wdata, mem_we,
        input  mem_rdata
    );

    modport master (
        output cpu_re, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_stall,
        output dma_req, dma_we, dma_addr, dma_len, dma_wdata,
        input  dma_gnt, dma_wready, dma_rvalid, dma_rdata, dma_done,
        input  mem_addr, mem_wdata, mem_we,
        output mem_rdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data memory between the CPU (fixed
// priority) and one burst DMA requester. The DMA burst uses every cycle the
// CPU leaves free.
// Optional build macro DMEM_ARB_FAIR_EN: after MAX_WAIT consecutive blocked
// DMA cycles, the CPU is stalled for one cycle and the DMA takes the port.
module dmem_arbiter #(
    parameter int          AW       = 11,
    parameter logic [31:0] BASE     = 32'h10010000,
    parameter int          MAX_WAIT = 4
) (
    input  logic          clk,
    input  logic          reset,
    dmem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, BURST, DONE} state_t;

    state_t        state_reg, state_next;
    logic [7:0]    beat_reg, beat_next;     // beat index k within the burst
    logic [AW-1:0] addr_reg, addr_next;     // word address of beat k
    logic [8:0]    len_reg, len_next;       // burst length, 1..256
    logic          dir_reg, dir_next;       // 1 = write burst
    logic          dma_gnt_reg, dma_rvalid_reg, dma_done_reg;
    logic [31:0]   dma_rdata_reg;

    logic cpu_req, cpu_owns, dma_wants, force_dma;
    logic grant, beat;

    // Byte address to dmem word: offset from BASE, drop byte lane, wrap at 2^AW.
    function automatic logic [AW-1:0] to_word(input logic [31:0] byte_addr);
        return AW'((byte_addr - BASE) >> 2);
    endfunction

    assign cpu_req   = bus.cpu_re | bus.cpu_we;
    assign dma_wants = ((state_reg == IDLE) && bus.dma_req) || (state_reg == BURST);
    assign cpu_owns  = cpu_req && !force_dma;
    assign bus.cpu_stall = force_dma;

`ifdef DMEM_ARB_FAIR_EN
    localparam int WW = $clog2(MAX_WAIT + 1);
    logic [WW-1:0] wait_reg, wait_next;

    assign force_dma = dma_wants && cpu_req && (wait_reg == WW'(MAX_WAIT));

    // Count consecutive cycles the CPU took the port away from a waiting DMA.
    always_comb begin
        wait_next = wait_reg;
        if (grant || beat)
            wait_next = '0;
        else if ((state_reg == BURST) && (state_next != BURST))
            wait_next = '0;
        else if (dma_wants && cpu_owns)
            wait_next = wait_reg + WW'(1);
    end

    // Wait counter register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            wait_reg <= '0;
        else
            wait_reg <= wait_next;
    end
`else
    // Strict CPU priority: the threshold is only meaningful with the counter.
    logic max_wait_unused;
    assign max_wait_unused = (MAX_WAIT != 0);
    assign force_dma = 1'b0;
`endif

    // Next-state logic: accept a burst in IDLE, step beats in BURST.
    always_comb begin
        state_next = state_reg;
        beat_next  = beat_reg;
        addr_next  = addr_reg;
        len_next   = len_reg;
        dir_next   = dir_reg;
        grant      = 1'b0;
        beat       = 1'b0;
        case (state_reg)
            IDLE: begin
                if (bus.dma_req && !cpu_owns) begin
                    grant      = 1'b1;
                    addr_next  = to_word(bus.dma_addr);
                    len_next   = (bus.dma_len == 8'd0) ? 9'd256 : {1'b0, bus.dma_len};
                    dir_next   = bus.dma_we;
                    beat_next  = 8'd0;
                    state_next = BURST;
                end
            end
            BURST: begin
                if (!cpu_owns) begin
                    beat      = 1'b1;
                    addr_next = addr_reg + {{(AW-1){1'b0}}, 1'b1};
                    if ({1'b0, beat_reg} == (len_reg - 9'd1)) begin
                        beat_next  = 8'd0;
                        state_next = DONE;
                    end else begin
                        beat_next = beat_reg + 8'd1;
                    end
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Memory port mux: CPU first, then a DMA beat, otherwise quiet.
    always_comb begin
        bus.mem_addr  = '0;
        bus.mem_wdata = 32'd0;
        bus.mem_we    = 1'b0;
        if (cpu_owns) begin
            bus.mem_addr  = to_word(bus.cpu_addr);
            bus.mem_wdata = bus.cpu_wdata;
            bus.mem_we    = bus.cpu_we;
        end else if (beat) begin
            bus.mem_addr  = addr_reg;
            bus.mem_wdata = dir_reg ? bus.dma_wdata : 32'd0;
            bus.mem_we    = dir_reg;
        end
    end

    assign bus.cpu_rdata  = bus.mem_rdata;
    assign bus.dma_wready = beat && dir_reg;
    assign bus.dma_gnt    = dma_gnt_reg;
    assign bus.dma_rvalid = dma_rvalid_reg;
    assign bus.dma_rdata  = dma_rdata_reg;
    assign bus.dma_done   = dma_done_reg;

    // State and handshake registers; reset aborts any burst silently.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg      <= IDLE;
            beat_reg       <= 8'd0;
            addr_reg       <= '0;
            len_reg        <= 9'd0;
            dir_reg        <= 1'b0;
            dma_gnt_reg    <= 1'b0;
            dma_rvalid_reg <= 1'b0;
            dma_done_reg   <= 1'b0;
            dma_rdata_reg  <= 32'd0;
        end else begin
            state_reg      <= state_next;
            beat_reg       <= beat_next;
            addr_reg       <= addr_next;
            len_reg        <= len_next;
            dir_reg        <= dir_next;
            dma_gnt_reg    <= grant;
            dma_rvalid_reg <= beat && !dir_reg;
            dma_done_reg   <= beat && (state_next == DONE);
            if (beat && !dir_reg)
                dma_rdata_reg <= bus.mem_rdata;
        end
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a memory model and scoreboard queues
// for memory writes and DMA read beats.
module tb_dmem_arbiter;
    localparam int          AW   = 11;
    localparam logic [31:0] BASE = 32'h10010000;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    dmem_arbiter_if #(.AW(AW)) bus();

    dmem_arbiter #(.AW(AW), .BASE(BASE), .MAX_WAIT(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [31:0] mem_model [0:(1<<AW)-1];
    assign bus.mem_rdata = mem_model[bus.mem_addr];

    typedef struct {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } wr_t;

    wr_t         exp_wr_q[$];
    logic [31:0] exp_rd_q[$];
    int n_checks = 0;
    int n_fail   = 0;
    int last_gnt_wait = -1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] pat(input logic [7:0] seed, input int k);
        return {seed, 8'h5A, 16'(k)};
    endfunction

    // Memory write monitor: the model memory samples the strobe on the falling edge.
    always @(negedge clk) begin
        if (bus.mem_we === 1'b1) begin
            mem_model[bus.mem_addr] <= bus.mem_wdata;
            n_checks++;
            assert (exp_wr_q.size() != 0) else begin
                n_fail++;
                $error("FAIL wr_unexpected: observed write word %h data %h expected none",
                       bus.mem_addr, bus.mem_wdata);
            end
            if (exp_wr_q.size() != 0) begin
                wr_t e;
                e = exp_wr_q.pop_front();
                check("wr_addr", 32'(bus.mem_addr), 32'(e.addr));
                check("wr_data", bus.mem_wdata, e.data);
                $display("mem write word %h data %h", bus.mem_addr, bus.mem_wdata);
            end
        end
    end

    // DMA read beat monitor.
    always @(negedge clk) begin
        if (bus.dma_rvalid === 1'b1) begin
            n_checks++;
            assert (exp_rd_q.size() != 0) else begin
                n_fail++;
                $error("FAIL rd_unexpected: observed rvalid data %h expected none", bus.dma_rdata);
            end
            if (exp_rd_q.size() != 0) begin
                logic [31:0] e;
                e = exp_rd_q.pop_front();
                check("rd_data", bus.dma_rdata, e);
                $display("dma read beat data %h", bus.dma_rdata);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One DMA burst. cpu_at: burst-relative cycle of a CPU store (-1 none).
    // abort_at: cycle at which reset is asserted (-1 none).
    task automatic do_burst(input string tag, input logic we, input logic [31:0] addr,
                            input logic [7:0] len, input logic [AW-1:0] exp_word,
                            input logic [7:0] seed, input int cpu_at,
                            input logic [31:0] cpu_a, input logic [AW-1:0] cpu_word,
                            input logic [31:0] cpu_d, input int abort_at, input int exp_done);
        int  nbeats;
        int  b;
        int  done_at;
        bit  got;
        bit  adv;
        nbeats = (len == 8'd0) ? 256 : int'(len);
        for (int k = 0; k < nbeats; k++) begin
            if (k == cpu_at) exp_wr_q.push_back('{cpu_word, cpu_d});
            if (abort_at >= 0 && k >= abort_at) break;
            if (we) exp_wr_q.push_back('{exp_word + AW'(k), pat(seed, k)});
            else    exp_rd_q.push_back(mem_model[exp_word + AW'(k)]);
        end
        bus.dma_req   = 1'b1;
        bus.dma_we    = we;
        bus.dma_addr  = addr;
        bus.dma_len   = len;
        bus.dma_wdata = pat(seed, 0);
        got = 1'b0;
        for (int t = 0; t < 50; t++) begin
            tick();
            if (bus.dma_gnt === 1'b1) begin
                got = 1'b1;
                last_gnt_wait = t;
                break;
            end
        end
        check({tag, "_gnt_seen"}, 32'(got), 32'd1);
        bus.dma_req = 1'b0;
        if (!got) return;
        b = 0;
        adv = 1'b0;
        done_at = -1;
        for (int i = 0; i < 400; i++) begin
            if (i > 0) tick();
            if (adv) bus.dma_wdata = pat(seed, b);
            adv = 1'b0;
            if (abort_at >= 0 && i == abort_at) begin
                reset = 1'b1;
                #1;
                check({tag, "_abort_we"}, 32'(bus.mem_we), 32'd0);
                repeat (2) begin
                    tick();
                    check({tag, "_abort_done"}, 32'(bus.dma_done), 32'd0);
                    check({tag, "_abort_gnt"}, 32'(bus.dma_gnt), 32'd0);
                end
                reset = 1'b0;
                break;
            end
            bus.cpu_we    = (i == cpu_at);
            bus.cpu_addr  = cpu_a;
            bus.cpu_wdata = cpu_d;
            #1;
            if (i == 1) check({tag, "_gnt_pulse"}, 32'(bus.dma_gnt), 32'd0);
            if (bus.cpu_we) begin
                check({tag, "_cpu_stall"}, 32'(bus.cpu_stall), 32'd0);
                check({tag, "_wready_blocked"}, 32'(bus.dma_wready), 32'd0);
            end
            if (bus.dma_done === 1'b1) begin
                done_at = i;
                if (!we) check({tag, "_rvalid_with_done"}, 32'(bus.dma_rvalid), 32'd1);
                break;
            end
            if (bus.dma_wready === 1'b1) begin
                b++;
                adv = 1'b1;
            end
        end
        bus.cpu_we = 1'b0;
        if (abort_at < 0) begin
            check({tag, "_done_cycle"}, 32'(done_at), 32'(exp_done));
            $display("burst %s done at cycle %0d", tag, done_at);
        end
        repeat (2) tick();
        check({tag, "_wr_q_empty"}, 32'(exp_wr_q.size()), 32'd0);
        check({tag, "_rd_q_empty"}, 32'(exp_rd_q.size()), 32'd0);
        exp_wr_q.delete();
        exp_rd_q.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected test end");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < (1 << AW); i++) mem_model[i] = 32'd0;
        mem_model[11'h7FF] = 32'hDEAD07FF;
        mem_model[11'h000] = 32'h0000BEEF;
        bus.cpu_re = 0; bus.cpu_we = 0; bus.cpu_addr = 0; bus.cpu_wdata = 0;
        bus.dma_req = 1; bus.dma_we = 1; bus.dma_addr = 32'h10010010;
        bus.dma_len = 8'd3; bus.dma_wdata = 0;

        // Reset held with a pending request: everything quiet.
        repeat (2) tick();
        check("rst_gnt", 32'(bus.dma_gnt), 32'd0);
        check("rst_rvalid", 32'(bus.dma_rvalid), 32'd0);
        check("rst_done", 32'(bus.dma_done), 32'd0);
        check("rst_rdata", bus.dma_rdata, 32'd0);
        check("rst_mem_we", 32'(bus.mem_we), 32'd0);
        check("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
        check("rst_wready", 32'(bus.dma_wready), 32'd0);
        check("rst_stall", 32'(bus.cpu_stall), 32'd0);
        reset = 1'b0;

        // Write burst words 4..6 right after reset release.
        do_burst("wr3", 1'b1, 32'h10010010, 8'd3, 11'd4, 8'hA1, -1, 0, 0, 0, -1, 3);
        check("gnt_latency", 32'(last_gnt_wait), 32'd0);

        // Read burst wrapping from the top word to word 0.
        do_burst("rdwrap", 1'b0, 32'h10011FFC, 8'd2, 11'h7FF, 8'h00, -1, 0, 0, 0, -1, 2);

        // CPU store during the second beat: CPU wins, DMA beat deferred.
        do_burst("contend", 1'b1, 32'h10010040, 8'd4, 11'h010, 8'hC3, 1,
                 32'h10010020, 11'd8, 32'hCAFE0008, -1, 5);

        // CPU store out of range wraps to word 1; CPU load reads it back.
        bus.cpu_we = 1; bus.cpu_addr = 32'h10012004; bus.cpu_wdata = 32'h12345678;
        exp_wr_q.push_back('{11'd1, 32'h12345678});
        #1;
        check("cpu_wr_addr", 32'(bus.mem_addr), 32'd1);
        tick();
        bus.cpu_we = 0; bus.cpu_re = 1; bus.cpu_addr = 32'h10010004;
        #1;
        check("cpu_rd_data", bus.cpu_rdata, 32'h12345678);
        check("cpu_rd_we", 32'(bus.mem_we), 32'd0);
        tick();
        bus.cpu_re = 0;
        #1;
        check("idle_addr", 32'(bus.mem_addr), 32'd0);
        check("idle_wdata", bus.mem_wdata, 32'd0);

        // CPU load activity holds off a pending request.
        bus.cpu_re = 1; bus.cpu_addr = 32'h10010000;
        bus.dma_req = 1; bus.dma_we = 0; bus.dma_addr = 32'h10010010; bus.dma_len = 8'd1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("cpu_prio_gnt", 32'(bus.dma_gnt), 32'd0);
        end
        bus.cpu_re = 0;
        do_burst("rd1", 1'b0, 32'h10010010, 8'd1, 11'd4, 8'h00, -1, 0, 0, 0, -1, 1);

        // Reset after two beats aborts silently; no stray activity afterwards.
        do_burst("abort", 1'b1, 32'h10010080, 8'd4, 11'h020, 8'hD4, -1, 0, 0, 0, 2, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("post_abort_gnt", 32'(bus.dma_gnt), 32'd0);
            check("post_abort_done", 32'(bus.dma_done), 32'd0);
        end
        do_burst("restart", 1'b1, 32'h10010080, 8'd4, 11'h020, 8'hE5, -1, 0, 0, 0, -1, 4);

        // Length 0 means 256 beats.
        do_burst("len256", 1'b1, 32'h10010400, 8'd0, 11'h100, 8'hF6, -1, 0, 0, 0, -1, 256);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
